// File: rtl/minisys_mem_stage_if.sv
// minisys_mem_stage_if
//
// Purpose: bundles every signal between the EXE/MEM pipeline register,
// the MEM stage and the writeback side into one interface, so the stage
// has a single bus port next to its clock and reset.
//
// Signals (direction seen from the stage, i.e. the slave modport):
//   regwrite_m, mem2reg_m, branch_m, zero_m   in  : control from EXE
//   mem_read_m, mem_write_m                   in  : memory access request
//   mem_size_m[1:0]                           in  : 00 byte, 01 half, else word
//   mem_unsigned_m                            in  : zero-extend loads when 1
//   alu_out_m[31:0]                           in  : byte address / ALU result
//   write_data_m[31:0]                        in  : store data, right-justified
//   write_reg_m[4:0]                          in  : destination register
//   pc_src_m                                  out : branch taken (combinational)
//   stall_m                                   out : upstream holds *_m while high
//   regwrite_w, mem2reg_w                     out : registered WB control
//   alu_out_w[31:0], read_data_w[31:0]        out : registered WB data
//   write_reg_w[4:0]                          out : registered WB destination
//   misalign_w                                out : registered misalignment flag
//
// The master modport is the pipeline side that drives the *_m signals.

interface minisys_mem_stage_if;

    logic        regwrite_m;
    logic        mem2reg_m;
    logic        branch_m;
    logic        zero_m;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [1:0]  mem_size_m;
    logic        mem_unsigned_m;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [4:0]  write_reg_m;

    logic        pc_src_m;
    logic        stall_m;
    logic        regwrite_w;
    logic        mem2reg_w;
    logic [31:0] alu_out_w;
    logic [31:0] read_data_w;
    logic [4:0]  write_reg_w;
    logic        misalign_w;

    modport master (
        output regwrite_m, mem2reg_m, branch_m, zero_m,
               mem_read_m, mem_write_m, mem_size_m, mem_unsigned_m,
               alu_out_m, write_data_m, write_reg_m,
        input  pc_src_m, stall_m, regwrite_w, mem2reg_w,
               alu_out_w, read_data_w, write_reg_w, misalign_w
    );

    modport slave (
        input  regwrite_m, mem2reg_m, branch_m, zero_m,
               mem_read_m, mem_write_m, mem_size_m, mem_unsigned_m,
               alu_out_m, write_data_m, write_reg_m,
        output pc_src_m, stall_m, regwrite_w, mem2reg_w,
               alu_out_w, read_data_w, write_reg_w, misalign_w
    );

endinterface

// File: rtl/minisys_mem_stage.sv
// minisys_mem_stage
//
// Purpose: MEM->WB stage of the Minisys pipeline. Performs byte, halfword
// and word loads/stores on an internal little-endian data RAM of
// 2^ADDR_W 32-bit words, sign- or zero-extends loaded data, inserts
// LATENCY wait states per access (stalling upstream) and registers the
// writeback bundle. Also produces the branch decision pc_src_m for IF.
//
// Parameters:
//   ADDR_W  : word-address bits of the RAM (addresses wrap modulo RAM size)
//   LATENCY : extra wait cycles per memory access, 0..15
//
// Ports:
//   clk : rising-edge clock
//   clr : synchronous active-high reset (RAM contents are not cleared)
//   bus : minisys_mem_stage_if.slave, all pipeline-facing signals
//
// Build option:
//   MEM_MISALIGN_EXC_EN - when defined, a misaligned halfword/word access is
//   flagged on misalign_w, its store is dropped, its register write is
//   cancelled and it takes no wait states. When undefined, misalign_w is
//   always 0 and the low address bits are forced to natural alignment.

module minisys_mem_stage #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 0
) (
    input  logic               clk,
    input  logic               clr,
    minisys_mem_stage_if.slave bus
);

    localparam int         RAM_WORDS = 1 << ADDR_W;
    localparam logic [3:0] LAT_CNT   = 4'(LATENCY);
    localparam logic       HAS_WAIT  = (LATENCY != 0);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [3:0]        waitCnt;
    logic [3:0]        nextWaitCnt;

    logic              accessReq;
    logic              misalign;
    logic              stall;
    logic              wUpdate;
    logic              complete;
    logic              storeEn;

    logic [1:0]        byteOff;
    logic [ADDR_W-1:0] ramIndex;
    logic [3:0]        byteEn;
    logic [31:0]       storeData;
    logic [31:0]       ramWord;
    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic [31:0]       loadData;

    logic [31:0]       ram [RAM_WORDS];

    // Branch decision goes straight through; it never waits on memory.
    assign bus.pc_src_m = bus.branch_m & bus.zero_m;

    // Address decode. The byte offset inside the word is forced to the
    // natural alignment of the access size, so a misaligned request that is
    // allowed to proceed simply touches the aligned halfword/word. Address
    // bits above the RAM index are dropped, which makes addresses alias.
    always_comb begin
        accessReq = bus.mem_read_m | bus.mem_write_m;
        ramIndex  = bus.alu_out_m[ADDR_W+1:2];
        case (bus.mem_size_m)
            2'b00:   byteOff = bus.alu_out_m[1:0];
            2'b01:   byteOff = {bus.alu_out_m[1], 1'b0};
            default: byteOff = 2'b00;
        endcase
    end

`ifdef MEM_MISALIGN_EXC_EN
    // A halfword on an odd address or a word off a 4-byte boundary is a
    // misaligned access; bytes can never be misaligned.
    always_comb begin
        misalign = 1'b0;
        if (accessReq) begin
            case (bus.mem_size_m)
                2'b00:   misalign = 1'b0;
                2'b01:   misalign = bus.alu_out_m[0];
                default: misalign = (bus.alu_out_m[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Store formatting: the right-justified store data is replicated across
    // the word so that whichever lanes are enabled already hold the right
    // bytes, and only the lanes covered by the access size are enabled.
    always_comb begin
        byteEn    = 4'b1111;
        storeData = bus.write_data_m;
        case (bus.mem_size_m)
            2'b00: begin
                byteEn    = 4'b0001 << byteOff;
                storeData = {4{bus.write_data_m[7:0]}};
            end
            2'b01: begin
                byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
                storeData = {2{bus.write_data_m[15:0]}};
            end
            default: begin
                byteEn    = 4'b1111;
                storeData = bus.write_data_m;
            end
        endcase
    end

    // Asynchronous read port. Because the W register samples this before
    // the RAM write lands on the same edge, the port behaves read-first.
    assign ramWord = ram[ramIndex];

    // Load formatting: pick the addressed byte or halfword out of the
    // little-endian word, then sign- or zero-extend it.
    always_comb begin
        loadByte = ramWord[{byteOff, 3'b000} +: 8];
        loadHalf = byteOff[1] ? ramWord[31:16] : ramWord[15:0];
        case (bus.mem_size_m)
            2'b00: begin
                loadData = bus.mem_unsigned_m ? {24'h000000, loadByte}
                                              : {{24{loadByte[7]}}, loadByte};
            end
            2'b01: begin
                loadData = bus.mem_unsigned_m ? {16'h0000, loadHalf}
                                              : {{16{loadHalf[15]}}, loadHalf};
            end
            default: begin
                loadData = ramWord;
            end
        endcase
    end

    // State register for the wait-state sequencer. A reset in the middle of
    // a wait simply drops the access; the store is only ever performed on
    // the completion cycle, so nothing reaches the RAM.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= ST_IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Next-state logic. An access with wait states leaves IDLE with the
    // counter loaded to LATENCY and stalls from that very cycle; WAIT counts
    // down and the cycle that sees a count of 1 is the completion cycle, so
    // stall is high for exactly LATENCY cycles. Misaligned accesses that
    // raise the flag complete immediately without wait states.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        stall       = 1'b0;
        wUpdate     = 1'b0;
        complete    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accessReq && !misalign && HAS_WAIT) begin
                    nextState   = ST_WAIT;
                    nextWaitCnt = LAT_CNT;
                    stall       = 1'b1;
                end else begin
                    wUpdate  = 1'b1;
                    complete = accessReq && !misalign;
                end
            end
            ST_WAIT: begin
                nextWaitCnt = (waitCnt != 4'd0) ? (waitCnt - 4'd1) : 4'd0;
                if (waitCnt <= 4'd1) begin
                    nextState = ST_IDLE;
                    wUpdate   = 1'b1;
                    complete  = accessReq && !misalign;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                nextState   = ST_IDLE;
                nextWaitCnt = 4'd0;
            end
        endcase
    end

    assign bus.stall_m = stall & ~clr;

    // The store happens once, on the completion edge, and never on an edge
    // where reset is also being applied.
    assign storeEn = complete & bus.mem_write_m & ~clr;

    // Data RAM write port with per-byte lane enables. No reset: contents
    // survive clr.
    always_ff @(posedge clk) begin
        if (storeEn) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    ram[ramIndex][8*i +: 8] <= storeData[8*i +: 8];
                end
            end
        end
    end

    // Writeback register. On a non-stalled edge it captures the M-side
    // bundle; load data only appears for a load that actually completed,
    // otherwise read_data_w is 0. While stalled the downstream sees a
    // bubble (no register write, no mem2reg) with the data fields held.
    always_ff @(posedge clk) begin
        if (clr) begin
            bus.regwrite_w  <= 1'b0;
            bus.mem2reg_w   <= 1'b0;
            bus.alu_out_w   <= 32'h0000_0000;
            bus.read_data_w <= 32'h0000_0000;
            bus.write_reg_w <= 5'd0;
            bus.misalign_w  <= 1'b0;
        end else if (wUpdate) begin
            bus.regwrite_w  <= bus.regwrite_m & ~misalign;
            bus.mem2reg_w   <= bus.mem2reg_m;
            bus.alu_out_w   <= bus.alu_out_m;
            bus.read_data_w <= (complete && bus.mem_read_m) ? loadData : 32'h0000_0000;
            bus.write_reg_w <= bus.write_reg_m;
            bus.misalign_w  <= misalign;
        end else begin
            bus.regwrite_w  <= 1'b0;
            bus.mem2reg_w   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_minisys_mem_stage.sv
// tb_minisys_mem_stage
//
// Purpose: self-checking bench for minisys_mem_stage. Two instances share
// the clock and the same M-side stimulus: one with no wait states and one
// with three. Each has its own byte-addressed reference memory, so loads,
// stores, extension, stall timing, bubbles and an aborted store are all
// checked against expectations computed from the stage's behaviour rules.
// Honours MEM_MISALIGN_EXC_EN the same way the design does.

module tb_minisys_mem_stage;

    localparam int ADDR_W = 14;
    localparam int LAT3   = 3;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        regwrite;
        logic        mem2reg;
        logic        branch;
        logic        zero;
        logic [4:0]  wreg;
    } opT;

    logic        clk = 1'b0;
    logic        clr0;
    logic        clr3;
    int          testCount = 0;
    int          failCount = 0;
    logic [31:0] lastAlu3;
    logic [31:0] rdata;
    logic [7:0]  model [2][256];

    always #5 clk = ~clk;

    minisys_mem_stage_if bus0 ();
    minisys_mem_stage_if bus3 ();

    minisys_mem_stage #(.ADDR_W(ADDR_W), .LATENCY(0)) dut0 (
        .clk (clk),
        .clr (clr0),
        .bus (bus0)
    );

    minisys_mem_stage #(.ADDR_W(ADDR_W), .LATENCY(LAT3)) dut3 (
        .clk (clk),
        .clr (clr3),
        .bus (bus3)
    );

    // Single point of comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic opT mkOp(input logic rd, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata);
        opT op;
        op.rd       = rd;
        op.wr       = wr;
        op.size     = size;
        op.uns      = uns;
        op.addr     = addr;
        op.wdata    = wdata;
        op.regwrite = rd ? 1'b1 : 1'($urandom_range(0, 1));
        op.mem2reg  = rd;
        op.branch   = 1'($urandom_range(0, 1));
        op.zero     = 1'($urandom_range(0, 1));
        op.wreg     = 5'($urandom_range(0, 31));
        return op;
    endfunction

    // Misalignment only exists as an exception when the option is built in.
    function automatic logic isMis(input opT op);
`ifdef MEM_MISALIGN_EXC_EN
        return (op.rd | op.wr) &&
               ((op.size == 2'b01 && op.addr[0]) || (op.size[1] && op.addr[1:0] != 2'b00));
`else
        return 1'b0 & op.rd;
`endif
    endfunction

    // Naturally aligned byte address, folded into the 256-byte test window
    // (the window is far below the RAM size, so aliasing folds onto it too).
    function automatic int winAddr(input opT op);
        logic [31:0] a;
        case (op.size)
            2'b00:   a = op.addr;
            2'b01:   a = op.addr & 32'hffff_fffe;
            default: a = op.addr & 32'hffff_fffc;
        endcase
        return int'(a & 32'h0000_00ff);
    endfunction

    function automatic logic [31:0] modelLoad(input int d, input opT op);
        int          a;
        logic [7:0]  b;
        logic [15:0] h;
        a = winAddr(op);
        case (op.size)
            2'b00: begin
                b = model[d][a];
                return op.uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = {model[d][a+1], model[d][a]};
                return op.uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return {model[d][a+3], model[d][a+2], model[d][a+1], model[d][a]};
        endcase
    endfunction

    task automatic modelStore(input int d, input opT op);
        int a;
        int n;
        a = winAddr(op);
        n = (op.size == 2'b00) ? 1 : (op.size == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) model[d][a+k] = op.wdata[8*k +: 8];
    endtask

    task automatic applyStimulus(input opT op);
        bus0.mem_read_m     = op.rd;      bus3.mem_read_m     = op.rd;
        bus0.mem_write_m    = op.wr;      bus3.mem_write_m    = op.wr;
        bus0.mem_size_m     = op.size;    bus3.mem_size_m     = op.size;
        bus0.mem_unsigned_m = op.uns;     bus3.mem_unsigned_m = op.uns;
        bus0.alu_out_m      = op.addr;    bus3.alu_out_m      = op.addr;
        bus0.write_data_m   = op.wdata;   bus3.write_data_m   = op.wdata;
        bus0.regwrite_m     = op.regwrite; bus3.regwrite_m    = op.regwrite;
        bus0.mem2reg_m      = op.mem2reg; bus3.mem2reg_m      = op.mem2reg;
        bus0.branch_m       = op.branch;  bus3.branch_m       = op.branch;
        bus0.zero_m         = op.zero;    bus3.zero_m         = op.zero;
        bus0.write_reg_m    = op.wreg;    bus3.write_reg_m    = op.wreg;
    endtask

    // Compares one instance's writeback bundle with what the op should give.
    task automatic checkW(input int d, input opT op, input logic mis, input logic [31:0] expRd);
        string       p;
        logic        rw, m2r, maw;
        logic [31:0] alu, rdat;
        logic [4:0]  wr;
        p = (d == 0) ? "dut0" : "dut3";
        if (d == 0) begin
            rw = bus0.regwrite_w; m2r = bus0.mem2reg_w; maw = bus0.misalign_w;
            alu = bus0.alu_out_w; rdat = bus0.read_data_w; wr = bus0.write_reg_w;
        end else begin
            rw = bus3.regwrite_w; m2r = bus3.mem2reg_w; maw = bus3.misalign_w;
            alu = bus3.alu_out_w; rdat = bus3.read_data_w; wr = bus3.write_reg_w;
        end
        checkOutput({p, ".regwrite_w"}, 32'(rw), 32'(op.regwrite & ~mis));
        checkOutput({p, ".mem2reg_w"}, 32'(m2r), 32'(op.mem2reg));
        checkOutput({p, ".alu_out_w"}, alu, op.addr);
        checkOutput({p, ".write_reg_w"}, 32'(wr), 32'(op.wreg));
        checkOutput({p, ".misalign_w"}, 32'(maw), 32'(mis));
        if (!mis) checkOutput({p, ".read_data_w"}, rdat, expRd);
    endtask

    // Runs one op on both instances, called just after a rising edge.
    // Returns the no-wait instance's read data for literal spot checks.
    task automatic runOp(input opT op, output logic [31:0] rdata0);
        logic        acc, mis;
        int          n;
        logic [31:0] exp0, exp3;
        acc  = op.rd | op.wr;
        mis  = isMis(op);
        n    = (acc && !mis) ? LAT3 : 0;
        exp0 = (op.rd && !mis) ? modelLoad(0, op) : 32'h0;
        exp3 = (op.rd && !mis) ? modelLoad(1, op) : 32'h0;
        if (op.wr && !mis) begin
            modelStore(0, op);
            modelStore(1, op);
        end
        rdata0 = 32'h0;
        applyStimulus(op);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            checkOutput("dut0.stall_m", 32'(bus0.stall_m), 32'h0);
            checkOutput("dut3.stall_m", 32'(bus3.stall_m), 32'(c < n));
            if (c == 0) begin
                checkOutput("dut0.pc_src_m", 32'(bus0.pc_src_m), 32'(op.branch & op.zero));
                checkOutput("dut3.pc_src_m", 32'(bus3.pc_src_m), 32'(op.branch & op.zero));
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                checkW(0, op, mis, exp0);
                rdata0 = bus0.read_data_w;
            end
            if (c < n) begin
                checkOutput("dut3.bubble.regwrite_w", 32'(bus3.regwrite_w), 32'h0);
                checkOutput("dut3.bubble.mem2reg_w", 32'(bus3.mem2reg_w), 32'h0);
                checkOutput("dut3.bubble.alu_out_w", bus3.alu_out_w, lastAlu3);
            end
        end
        checkW(1, op, mis, exp3);
        lastAlu3 = op.addr;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        opT          op;
        opT          zeroOp;
        logic [31:0] oldWord;
        int          kind;

        zeroOp = '0;

        // Reset both instances with an idle request on the bus.
        $display("[TB] reset");
        clr0 = 1'b1;
        clr3 = 1'b1;
        applyStimulus(zeroOp);
        repeat (2) @(posedge clk);
        #1;
        checkW(0, zeroOp, 1'b0, 32'h0);
        checkW(1, zeroOp, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("reset.dut0.stall_m", 32'(bus0.stall_m), 32'h0);
        checkOutput("reset.dut3.stall_m", 32'(bus3.stall_m), 32'h0);
        clr0 = 1'b0;
        clr3 = 1'b0;
        @(posedge clk);
        #1;
        lastAlu3 = 32'h0;

        // Give every word of the test window a known value.
        for (int a = 0; a < 256; a += 4) runOp(mkOp(1'b0, 1'b1, 2'b10, 1'b0, 32'(a), $urandom), rdata);

        $display("[TB] directed loads and stores");
        runOp(mkOp(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8badf00d), rdata);
        runOp(mkOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0), rdata);
        checkOutput("LW 0x10", rdata, 32'h8badf00d);
        runOp(mkOp(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0), rdata);
        checkOutput("LB 0x13", rdata, 32'hffffff8b);
        runOp(mkOp(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0), rdata);
        checkOutput("LBU 0x13", rdata, 32'h0000008b);
        runOp(mkOp(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0), rdata);
        checkOutput("LH 0x10", rdata, 32'hfffff00d);
        runOp(mkOp(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0), rdata);
        checkOutput("LHU 0x12", rdata, 32'h00008bad);
        runOp(mkOp(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h11223344), rdata);
        runOp(mkOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0), rdata);
        checkOutput("LW after SB", rdata, 32'h8bad440d);
        runOp(mkOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h10010, 32'h0), rdata);
        checkOutput("LW alias 0x10010", rdata, 32'h8bad440d);

        // Reset during the second wait cycle of a store on the slow instance.
        $display("[TB] reset during wait");
        op = mkOp(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hdeadbeef);
        oldWord = modelLoad(1, op);
        modelStore(0, op);
        applyStimulus(op);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abort.wait1.stall_m", 32'(bus3.stall_m), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abort.wait2.stall_m", 32'(bus3.stall_m), 32'h1);
        clr3 = 1'b1;
        @(posedge clk);
        #1;
        clr3 = 1'b0;
        applyStimulus(zeroOp);
        checkW(1, zeroOp, 1'b0, 32'h0);
        lastAlu3 = 32'h0;
        runOp(mkOp(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0), rdata);
        op = mkOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        checkOutput("abort.model3 kept", modelLoad(1, op), oldWord);
        runOp(op, rdata);
        checkOutput("LW 0x20 dut0", rdata, 32'hdeadbeef);

        // Misaligned word store onto the word at 0x20.
        $display("[TB] misaligned store");
        runOp(mkOp(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h5a5aa5a5), rdata);
        runOp(mkOp(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0), rdata);
`ifdef MEM_MISALIGN_EXC_EN
        checkOutput("LW 0x20 after misaligned SW", rdata, 32'hdeadbeef);
`else
        checkOutput("LW 0x20 after misaligned SW", rdata, 32'h5a5aa5a5);
`endif

        // Random traffic: idle, loads and stores of every size and alias.
        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 2));
            op = mkOp(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 255)) | (32'($urandom_range(0, 3)) << 16), $urandom);
            runOp(op, rdata);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/minisys_mem_stage.md
# minisys_mem_stage

Parametrised MEM→WB pipeline stage for the Minisys pipeline, the successor of the fixed word-only data-memory stage. Adds sized loads and stores (byte, halfword, word) with sign/zero extension and byte-lane generation, a configurable-depth internal data RAM, and a wait-state counter with a stall handshake so the pipeline can tolerate multi-cycle memory. Sits between the EXE/MEM register and the register-file writeback. It still produces the branch decision `pc_src_m` for IF.

## Interface
- `ADDR_W`, 14, word-address bits; RAM holds 2^ADDR_W 32-bit words.
- `LATENCY`, 0, extra wait cycles per memory access (0..15).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `regwrite_m`, `mem2reg_m`, `branch_m`, `zero_m` in 1: control from EXE.
- `mem_read_m`, `mem_write_m` in 1: access request.
- `mem_size_m` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `mem_unsigned_m` in 1: load zero-extends when 1.
- `alu_out_m` in 32: byte address or ALU result.
- `write_data_m` in 32: store data, right-justified.
- `write_reg_m` in 5: destination register.
- `pc_src_m` out 1: `branch_m & zero_m`, combinational.
- `stall_m` out 1: upstream must hold all `_m` inputs while high.
- `regwrite_w`, `mem2reg_w` out 1; `alu_out_w`, `read_data_w` out 32; `write_reg_w` out 5: registered WB outputs.
- `misalign_w` out 1: registered misalignment flag.

## Operation
- FSM states IDLE and WAIT, plus a 4-bit wait counter.
- IDLE, no access (`mem_read_m`=`mem_write_m`=0): W registers capture inputs at the next edge; `read_data_w`=0.
- IDLE, access with `LATENCY`=0: completes in the same cycle.
- IDLE, access with `LATENCY`>0: go to WAIT, counter=`LATENCY`, `stall_m`=1.
- WAIT: decrement each cycle; the cycle with counter=1 is the completion cycle (`stall_m`=0). Then return to IDLE.
- RAM index is `alu_out_m[ADDR_W+1:2]`; higher address bits are ignored, so addresses wrap modulo RAM size.
- Store commits only on the completion cycle, exactly once.
- Lane enables by size:
  - byte: lane `addr[1:0]`, data replicated ×4.
  - half: lanes {2,3} if `addr[1]`, else {0,1}; data replicated ×2.
  - word: all lanes.
- Load: select the byte or half by address, then sign-extend, or zero-extend if `mem_unsigned_m`. Little-endian.
- RAM is read-first: a load and store to the same word never coincide, but the read port returns the pre-write value.
- While `stall_m`=1, W outputs present a bubble: `regwrite_w`=0 and `mem2reg_w`=0, other W outputs hold.
- RAM contents are not reset.

## Timing
- Reset values: all W outputs 0, `stall_m`=0, state IDLE, counter 0.
- Reset mid-WAIT aborts the access: no store is committed and no writeback is issued.
- Latency from M inputs to W outputs is 1 + `LATENCY` cycles for accesses and 1 cycle for non-accesses.
- `stall_m` is high for exactly `LATENCY` cycles per access. It is a registered-state output (from the FSM), combinationally asserted in the IDLE cycle that starts the access.
- `pc_src_m` is independent of the stall.

## Configuration
- `MEM_MISALIGN_EXC_EN` defined:
  - half with `addr[0]`=1, or word with `addr[1:0]`≠0, sets `misalign_w`=1 with the W update.
  - The store is suppressed, `regwrite_w` is forced to 0, and no wait states are inserted.
- `MEM_MISALIGN_EXC_EN` undefined:
  - `misalign_w` is tied 0.
  - Low address bits are masked to natural alignment (half: `addr[0]`=0; word: `addr[1:0]`=0) and the access proceeds normally.

## Test plan
- Reset, `LATENCY`=0: SW 0x8badf00d @0x10, then LW @0x10 → next cycle `read_data_w`=0x8badf00d, `mem2reg_w`=1, `stall_m` never high.
- Byte/half extension: after the word above, LB @0x13 → 0xffffff8b; LBU @0x13 → 0x0000008b; LH @0x10 → 0xfffff00d; LHU @0x12 → 0x00008bad.
- Partial store: SB 0x11223344 @0x11 onto 0x8badf00d → LW @0x10 returns 0x8bad440d.
- `LATENCY`=3: LW issued → `stall_m` high 3 cycles, `regwrite_w`=0 during them, data at cycle 4. A store issued at the same point commits once, verified by a following read.
- Reset asserted in 2nd WAIT cycle of SW 0xdeadbeef @0x20 → no write (word retains prior value), all W outputs 0 next cycle.
- With `MEM_MISALIGN_EXC_EN`: SW @0x22 → `misalign_w`=1, `regwrite_w`=0, memory unchanged. Without the macro: the same SW writes word 0x20. `ADDR_W`=14: LW @0x10010 aliases 0x10.
